softmax_exp_sequencer: RTL and testbench

// - Sequences one softmax row through the shared 3-cycle Q4.12 exp unit: buffers N inputs, tracks row max,

---
 rtl/softmax_exp_sequencer.sv | 166 ++++++++++++++++
 tb/tb_softmax_exp_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_exp_sequencer.sv
// Softmax row sequencer: buffers N_ELEM scores and tracks their max. It streams (x - max) through a
// shared 3-cycle exp unit, collects clamped results with their sum, then replays them to the normaliser.
module softmax_exp_sequencer #(
   parameter int unsigned BIT_WIDTH = 16,
   parameter int unsigned N_ELEM    = 32,
   parameter int unsigned IDX_WIDTH = 5,
   parameter int unsigned SUM_WIDTH = 21
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [BIT_WIDTH-1:0] i_in_data,
   output logic                 o_exp_valid,
   output logic [BIT_WIDTH-1:0] o_exp_data,
   input  logic                 i_exp_valid,
   input  logic [BIT_WIDTH-1:0] i_exp_data,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [BIT_WIDTH-1:0] o_out_data,
   output logic [IDX_WIDTH-1:0] o_out_idx,
   output logic                 o_out_last,
   output logic [SUM_WIDTH-1:0] o_sum,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err
);

   typedef enum logic [2:0] {StIdle, StLoad, StIssue, StDrain, StOutput} state_e;

   localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(N_ELEM - 1);
   localparam logic [IDX_WIDTH:0]   RspFull = (IDX_WIDTH + 1)'(N_ELEM);

   state_e               state_q, state_d;
   logic [IDX_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic [IDX_WIDTH-1:0] iss_cnt_q, iss_cnt_d;
   logic [IDX_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic [IDX_WIDTH:0]   rsp_cnt_q, rsp_cnt_d;
   logic [BIT_WIDTH-1:0] max_q, max_d;
   logic [SUM_WIDTH-1:0] sum_q, sum_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   logic [BIT_WIDTH-1:0] in_buf  [N_ELEM];
   logic [BIT_WIDTH-1:0] exp_buf [N_ELEM];

   logic                 in_hs, out_hs, rsp_take, rsp_stray;
   logic [BIT_WIDTH-1:0] cur, exp_clamp, exp_sat;
   logic [BIT_WIDTH:0]   diff;

   assign in_hs  = o_in_ready & i_in_valid;
   assign out_hs = o_out_valid & i_out_ready;

   // Results are only legal while a row is in flight and not all N have arrived yet.
   assign rsp_take  = i_exp_valid & ((state_q == StIssue) | (state_q == StDrain)) &
                      (rsp_cnt_q != RspFull);
   assign rsp_stray = i_exp_valid & ~rsp_take;
   assign exp_clamp = i_exp_data[BIT_WIDTH-1] ? '0 : i_exp_data;

   // Difference in one extra bit, then saturate back into BIT_WIDTH.
   assign cur  = in_buf[iss_cnt_q];
   assign diff = {cur[BIT_WIDTH-1], cur} - {max_q[BIT_WIDTH-1], max_q};

   always_comb begin
      exp_sat = diff[BIT_WIDTH-1:0];
      if (diff[BIT_WIDTH] != diff[BIT_WIDTH-1]) begin
         exp_sat = diff[BIT_WIDTH] ? {1'b1, {(BIT_WIDTH-1){1'b0}}} : {1'b0, {(BIT_WIDTH-1){1'b1}}};
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      iss_cnt_d = iss_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      rsp_cnt_d = rsp_cnt_q;
      max_d     = max_q;
      sum_d     = sum_q;
      done_d    = 1'b0;
      err_d     = err_q | rsp_stray;

      if (rsp_take) begin
         rsp_cnt_d = rsp_cnt_q + 1'b1;
         sum_d     = sum_q + SUM_WIDTH'(exp_clamp);
      end

      unique case (state_q)
         StIdle: begin
            if (in_hs) begin
               max_d    = i_in_data;
               wr_cnt_d = wr_cnt_q + 1'b1;
               state_d  = StLoad;
            end
         end
         StLoad: begin
            if (in_hs) begin
               if ($signed(i_in_data) > $signed(max_q)) max_d = i_in_data;
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (wr_cnt_q == LastIdx) state_d = StIssue;
            end
         end
         StIssue: begin
            iss_cnt_d = iss_cnt_q + 1'b1;
            if (iss_cnt_q == LastIdx) state_d = StDrain;
         end
         StDrain: begin
            if (rsp_cnt_q == RspFull) state_d = StOutput;
         end
         StOutput: begin
            if (out_hs) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
               if (rd_cnt_q == LastIdx) begin
                  state_d   = StIdle;
                  done_d    = 1'b1;
                  sum_d     = '0;
                  rsp_cnt_d = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StIdle;
         wr_cnt_q  <= '0;
         iss_cnt_q <= '0;
         rd_cnt_q  <= '0;
         rsp_cnt_q <= '0;
         max_q     <= '0;
         sum_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         iss_cnt_q <= iss_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         rsp_cnt_q <= rsp_cnt_d;
         max_q     <= max_d;
         sum_q     <= sum_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Data buffers carry no reset; every entry is rewritten before it is read.
   always_ff @(posedge i_clk) begin
      if (in_hs) in_buf[wr_cnt_q] <= i_in_data;
      if (rsp_take) exp_buf[rsp_cnt_q[IDX_WIDTH-1:0]] <= exp_clamp;
   end

   assign o_in_ready  = (state_q == StIdle) | (state_q == StLoad);
   assign o_exp_valid = (state_q == StIssue);
   assign o_exp_data  = o_exp_valid ? exp_sat : '0;
   assign o_out_valid = (state_q == StOutput);
   assign o_out_data  = o_out_valid ? exp_buf[rd_cnt_q] : '0;
   assign o_out_idx   = rd_cnt_q;
   assign o_out_last  = o_out_valid & (rd_cnt_q == LastIdx);
   assign o_sum       = sum_q;
   assign o_busy      = (state_q != StIdle);
   assign o_done      = done_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_softmax_exp_sequencer.sv
// Bench for softmax_exp_sequencer: random rows against an arithmetic reference, with a 3-cycle
// behavioural exp unit, mid-row reset and stray-result scenarios.
module tb_softmax_exp_sequencer;

   localparam int BW = 16;
   localparam int N  = 32;
   localparam int IW = 5;
   localparam int SW = 21;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_in_valid;
   logic          o_in_ready;
   logic [BW-1:0] i_in_data;
   logic          o_exp_valid;
   logic [BW-1:0] o_exp_data;
   logic          i_exp_valid;
   logic [BW-1:0] i_exp_data;
   logic          o_out_valid;
   logic          i_out_ready;
   logic [BW-1:0] o_out_data;
   logic [IW-1:0] o_out_idx;
   logic          o_out_last;
   logic [SW-1:0] o_sum;
   logic          o_busy;
   logic          o_done;
   logic          o_err;

   softmax_exp_sequencer #(
      .BIT_WIDTH (BW),
      .N_ELEM    (N),
      .IDX_WIDTH (IW),
      .SUM_WIDTH (SW)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_in_data   (i_in_data),
      .o_exp_valid (o_exp_valid),
      .o_exp_data  (o_exp_data),
      .i_exp_valid (i_exp_valid),
      .i_exp_data  (i_exp_data),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_out_data  (o_out_data),
      .o_out_idx   (o_out_idx),
      .o_out_last  (o_out_last),
      .o_sum       (o_sum),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Behavioural exp unit: fixed 3-cycle latency, no backpressure, flushed by reset.
   int            exp_mode;
   logic          stray;
   logic [2:0]    pv;
   logic [BW-1:0] pd [3];

   function automatic int exp_model(input int op);
      if (exp_mode == 0) return 4096;
      return (op >>> 3) + 4091;
   endfunction

   always @(posedge i_clk) begin
      if (i_rst) begin
         pv    <= '0;
         pd[0] <= '0;
         pd[1] <= '0;
         pd[2] <= '0;
      end else begin
         pv    <= {pv[1:0], o_exp_valid};
         pd[0] <= BW'(exp_model(int'($signed(o_exp_data))));
         pd[1] <= pd[0];
         pd[2] <= pd[1];
      end
   end

   assign i_exp_valid = pv[2] | stray;
   assign i_exp_data  = pd[2];

   int req_q [$];
   int req_cyc [$];
   int done_cnt;

   always @(negedge i_clk) begin
      if (o_exp_valid) begin
         req_q.push_back(int'($signed(o_exp_data)));
         req_cyc.push_back(cyc);
      end
      if (o_done) done_cnt++;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic [BW-1:0] row [N];
   int            exp_op  [N];
   int            exp_val [N];
   int            exp_sum;
   int            exp_err;

   // Reference: softmax-row rules in plain integer arithmetic.
   task automatic compute_expect();
      int mx;
      int v;
      mx = int'($signed(row[0]));
      for (int i = 1; i < N; i++) if (int'($signed(row[i])) > mx) mx = int'($signed(row[i]));
      exp_sum = 0;
      for (int i = 0; i < N; i++) begin
         exp_op[i] = int'($signed(row[i])) - mx;
         if (exp_op[i] < -32768) exp_op[i] = -32768;
         v = exp_model(exp_op[i]);
         if (v < 0) v = 0;
         exp_val[i] = v;
         exp_sum += v;
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, " in_ready"},  int'(o_in_ready), 1);
      check({tag, " exp_valid"}, int'(o_exp_valid), 0);
      check({tag, " exp_data"},  int'(o_exp_data), 0);
      check({tag, " out_valid"}, int'(o_out_valid), 0);
      check({tag, " out_data"},  int'(o_out_data), 0);
      check({tag, " out_idx"},   int'(o_out_idx), 0);
      check({tag, " out_last"},  int'(o_out_last), 0);
      check({tag, " sum"},       int'(o_sum), 0);
      check({tag, " busy"},      int'(o_busy), 0);
      check({tag, " done"},      int'(o_done), 0);
      check({tag, " err"},       int'(o_err), 0);
   endtask

   task automatic feed_row(input int gap_pct, output int last_hs);
      int to;
      logic rdy;
      last_hs = 0;
      for (int i = 0; i < N; i++) begin
         for (int g = 0; g < 4 && $urandom_range(1, 100) <= gap_pct; g++) begin
            @(negedge i_clk);
            i_in_valid = 1'b0;
         end
         to = 0;
         do begin
            @(negedge i_clk);
            i_in_valid = 1'b1;
            i_in_data  = row[i];
            rdy        = o_in_ready;
            last_hs    = cyc;
            to++;
         end while (!rdy && to < 50);
         if (!rdy) check("in_ready timeout", 0, 1);
      end
      @(negedge i_clk);
      i_in_valid = 1'b0;
   endtask

   task automatic run_row(input int gap_pct, input int rdy_pct, input string tag);
      int last_hs;
      int first_out;
      int k;
      int to;
      @(posedge i_clk);
      req_q.delete();
      req_cyc.delete();
      done_cnt = 0;
      compute_expect();
      feed_row(gap_pct, last_hs);
      k = 0;
      first_out = -1;
      to = 0;
      while (k < N && to < 3000) begin
         @(negedge i_clk);
         to++;
         i_out_ready = ($urandom_range(1, 100) <= rdy_pct);
         if (o_out_valid && first_out < 0) first_out = cyc;
         if (o_out_valid && i_out_ready) begin
            check($sformatf("%s out_idx[%0d]", tag, k), int'(o_out_idx), k);
            check($sformatf("%s out_data[%0d]", tag, k), int'(o_out_data), exp_val[k]);
            check($sformatf("%s out_last[%0d]", tag, k), int'(o_out_last), (k == N - 1) ? 1 : 0);
            check($sformatf("%s sum[%0d]", tag, k), int'(o_sum), exp_sum);
            k++;
         end
      end
      if (k < N) check({tag, " output timeout"}, k, N);
      @(negedge i_clk);
      i_out_ready = 1'b0;
      repeat (3) @(negedge i_clk);
      check({tag, " done count"}, done_cnt, 1);
      check({tag, " busy after"}, int'(o_busy), 0);
      check({tag, " sum cleared"}, int'(o_sum), 0);
      check({tag, " err"}, int'(o_err), exp_err);
      check({tag, " req count"}, req_q.size(), N);
      for (int i = 0; i < N && i < req_q.size(); i++)
         check($sformatf("%s req[%0d]", tag, i), req_q[i], exp_op[i]);
      if (req_q.size() > 0) begin
         check({tag, " first req latency"}, req_cyc[0] - last_hs, 1);
         check({tag, " req span"}, req_cyc[req_cyc.size() - 1] - req_cyc[0], N - 1);
         check({tag, " first out latency"}, first_out - req_cyc[0], N + 4);
      end
   endtask

   initial begin
      int lh;
      int n;
      int to;
      i_rst       = 1'b1;
      i_in_valid  = 1'b0;
      i_in_data   = '0;
      i_out_ready = 1'b0;
      stray       = 1'b0;
      exp_mode    = 0;
      exp_err     = 0;
      repeat (3) @(negedge i_clk);
      check_reset("por");
      i_rst = 1'b0;

      for (int i = 0; i < N; i++) row[i] = '0;
      run_row(0, 100, "zeros");

      exp_mode = 1;
      for (int i = 0; i < N; i++) row[i] = BW'(i * 256);
      run_row(0, 100, "ramp");

      for (int i = 0; i < N; i++) row[i] = BW'($urandom_range(0, 4095));
      row[5]  = 16'h8000;
      row[20] = 16'h7FFF;
      run_row(10, 100, "sat");

      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < N; i++)
            row[i] = (r % 2 == 0) ? BW'($urandom) : BW'($urandom_range(0, 8191) - 4096);
         run_row(40, 50, $sformatf("rand%0d", r));
      end

      // Reset while the 11th operand (index 10) is on the exp port.
      for (int i = 0; i < N; i++) row[i] = BW'($urandom);
      @(posedge i_clk);
      feed_row(0, lh);
      n = 0;
      to = 0;
      while (to < 100) begin
         if (o_exp_valid) n++;
         if (n == 11) break;
         @(negedge i_clk);
         to++;
      end
      check("mid_rst reached iss 10", n, 11);
      i_rst = 1'b1;
      @(negedge i_clk);
      check_reset("mid_rst");
      i_rst = 1'b0;

      for (int i = 0; i < N; i++) row[i] = BW'($urandom);
      run_row(20, 50, "post_rst");

      @(negedge i_clk);
      stray = 1'b1;
      @(negedge i_clk);
      stray = 1'b0;
      check("stray err", int'(o_err), 1);
      check("stray busy", int'(o_busy), 0);
      check("stray in_ready", int'(o_in_ready), 1);
      exp_err = 1;
      repeat (3) @(negedge i_clk);
      check("stray err sticky", int'(o_err), 1);

      for (int i = 0; i < N; i++) row[i] = BW'($urandom);
      run_row(20, 50, "post_stray");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
